// File: rtl/calc_alu_seq.sv
// calc_alu_seq: multi-cycle add/sub/shift-add mul/restoring div with sequential double-dabble BCD.
// Optional: define CALC_DIV_ROUND_EN to round DIV quotients (half-up) instead of truncating.
module calc_dd_digit (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  logic [3:0] adj;
  assign adj  = (d >= 4'd5) ? d + 4'd3 : d;
  assign q    = {adj[2:0], cin};
  assign cout = adj[3];
endmodule

module calc_alu_seq #(
  parameter  int WIDTH  = 11,
  parameter  int DIGITS = 4,
  parameter  int FRAC   = 2,
  localparam int RES_W  = 2*WIDTH
) (
  input  logic                clk_ALU,
  input  logic                rst_ALU,
  input  logic [WIDTH-1:0]    in_numb,
  input  logic [1:0]          keys,
  input  logic [3:0]          arif,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [RES_W-1:0]    result,
  output logic                neg,
  output logic                div0,
  output logic                ovf,
  output logic [4*DIGITS-1:0] bcd,
  output logic [2:0]          dot_pos
);
  localparam int BCD_N = (RES_W*302 + 999)/1000 + 1;
  localparam int CNT_W = $clog2(RES_W+1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam logic [RES_W-1:0] POW_F = RES_W'(pow10(FRAC));
  localparam longint unsigned  MAX_V = pow10(DIGITS) - 1;

  typedef enum logic [1:0] {IDLE, CALC, BCD, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t             state;
  op_t                op, op_dec;
  logic               op_ok;
  logic [WIDTH-1:0]   a_r, b_r, wb;
  logic [RES_W-1:0]   a_ext, b_ext, wa, acc, res, sh, rem_sh, rem_nx, calc_val;
  logic [CNT_W-1:0]   cnt;
  logic [4*BCD_N-1:0] dd, dd_nx;
  logic [BCD_N:0]     cy;
  logic q_bit, calc_last, div_zero, sub_neg, neg_w, div0_w, ovf_c, dd_unused;

  assign a_ext     = {{(RES_W-WIDTH){1'b0}}, a_r};
  assign b_ext     = {{(RES_W-WIDTH){1'b0}}, wb};
  assign div_zero  = (wb == '0);
  assign sub_neg   = (wa < b_ext);
  assign ovf_c     = 64'(res) > MAX_V;
  assign cy[0]     = sh[RES_W-1];
  assign dd_unused = cy[BCD_N];

  always_comb begin
    op_ok  = 1'b1;
    op_dec = OP_ADD;
    case (arif)
      4'b1110: op_dec = OP_ADD;
      4'b1101: op_dec = OP_SUB;
      4'b1011: op_dec = OP_MUL;
      4'b0111: op_dec = OP_DIV;
      default: op_ok  = 1'b0;
    endcase
  end

  // One step of the running op; calc_val is the final value on the last CALC cycle
  always_comb begin
    rem_sh    = {acc[RES_W-2:0], wa[RES_W-1]};
    q_bit     = (rem_sh >= b_ext);
    rem_nx    = q_bit ? rem_sh - b_ext : rem_sh;
    calc_val  = '0;
    calc_last = 1'b0;
    case (op)
      OP_ADD: begin calc_val = wa + b_ext; calc_last = 1'b1; end
      OP_SUB: begin calc_val = sub_neg ? b_ext - wa : wa - b_ext; calc_last = 1'b1; end
      OP_MUL: begin
        calc_val  = wb[0] ? acc + wa : acc;
        calc_last = (cnt == CNT_W'(WIDTH-1));
      end
      default: begin
        calc_val = {wa[RES_W-2:0], q_bit};
`ifdef CALC_DIV_ROUND_EN
        if ((rem_nx + rem_nx) >= b_ext) calc_val = calc_val + 1'b1;
`endif
        if (div_zero) calc_val = '0;
        calc_last = div_zero || (cnt == CNT_W'(RES_W-1));
      end
    endcase
  end

  for (genvar g = 0; g < BCD_N; g++) begin : g_dig
    calc_dd_digit u_dig (
      .d(dd[4*g +: 4]), .cin(cy[g]), .q(dd_nx[4*g +: 4]), .cout(cy[g+1])
    );
  end

  always_ff @(posedge clk_ALU or posedge rst_ALU) begin
    if (rst_ALU) begin
      state <= IDLE;  op <= OP_ADD;
      a_r <= '0; b_r <= '0; wa <= '0; wb <= '0; acc <= '0; cnt <= '0;
      res <= '0; sh <= '0; dd <= '0; neg_w <= 1'b0; div0_w <= 1'b0;
      busy <= 1'b0; done <= 1'b0; result <= '0; neg <= 1'b0;
      div0 <= 1'b0; ovf <= 1'b0; bcd <= '0; dot_pos <= '0;
    end else begin
      done <= 1'b0;
      if (keys[1]) a_r <= in_numb;
      if (keys[0]) b_r <= in_numb;
      case (state)
        IDLE: if (start && op_ok) begin
          op    <= op_dec;
          wa    <= (op_dec == OP_DIV) ? a_ext * POW_F : a_ext;
          wb    <= b_r;
          acc   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          case (op)
            OP_MUL: begin acc <= calc_val; wa <= wa << 1; wb <= wb >> 1; end
            OP_DIV: begin acc <= rem_nx; wa <= {wa[RES_W-2:0], q_bit}; end
            default: ;
          endcase
          if (calc_last) begin
            res    <= calc_val;
            sh     <= calc_val;
            dd     <= '0;
            cnt    <= '0;
            neg_w  <= (op == OP_SUB) && sub_neg;
            div0_w <= (op == OP_DIV) && div_zero;
            state  <= ((op == OP_DIV) && div_zero) ? DONE : BCD;
          end
        end
        BCD: begin
          dd  <= dd_nx;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(RES_W-1)) state <= DONE;
        end
        DONE: begin
          result  <= res;
          neg     <= neg_w;
          div0    <= div0_w;
          ovf     <= ovf_c;
          bcd     <= ovf_c ? {DIGITS{4'h9}} : dd[4*DIGITS-1:0];
          dot_pos <= (op == OP_DIV) ? 3'(FRAC) : 3'd0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_alu_seq.sv
// Self-checking bench for calc_alu_seq: directed plan items plus random ops vs an arithmetic model.
module tb_calc_alu_seq;
  localparam int WIDTH = 11, DIGITS = 4, FRAC = 2, RES_W = 2*WIDTH;

  logic                clk_ALU = 1'b0, rst_ALU = 1'b1;
  logic [WIDTH-1:0]    in_numb = '0;
  logic [1:0]          keys = 2'b00;
  logic [3:0]          arif = 4'b1111;
  logic                start = 1'b0;
  logic                busy, done, neg, div0, ovf;
  logic [RES_W-1:0]    result;
  logic [4*DIGITS-1:0] bcd;
  logic [2:0]          dot_pos;

  int tot = 0, bad = 0;

  calc_alu_seq dut (
    .clk_ALU(clk_ALU), .rst_ALU(rst_ALU), .in_numb(in_numb), .keys(keys),
    .arif(arif), .start(start), .busy(busy), .done(done), .result(result),
    .neg(neg), .div0(div0), .ovf(ovf), .bcd(bcd), .dot_pos(dot_pos)
  );

  always #5 clk_ALU = ~clk_ALU;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input longint unsigned v);
    logic [15:0] d = '0;
    if (v > 9999) return 16'h9999;
    for (int i = 0; i < 4; i++) begin
      d[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk_ALU); #1;
  endtask

  task automatic run_op(input logic [3:0] op, input int a, input int b, input bit disturb);
    longint unsigned r, num;
    bit n_exp, z_exp;
    int lat, n;
    z_exp = 0; n_exp = 0; r = 0;
    case (op)
      4'b1110: begin r = longint'(a) + b; lat = 2 + RES_W; end
      4'b1101: begin n_exp = (a < b); r = n_exp ? b - a : a - b; lat = 2 + RES_W; end
      4'b1011: begin r = longint'(a) * b; lat = 1 + WIDTH + RES_W; end
      default: if (b == 0) begin
        z_exp = 1; lat = 2;
      end else begin
        num = longint'(a) * (10**FRAC);
        r = num / b;
`ifdef CALC_DIV_ROUND_EN
        if (2 * (num % b) >= b) r++;
`endif
        lat = 1 + 2*RES_W;
      end
    endcase
    keys = 2'b10; in_numb = WIDTH'(a); tick();
    keys = 2'b01; in_numb = WIDTH'(b); tick();
    keys = 2'b00; arif = op; start = 1'b1; tick();
    start = 1'b0;
    chk("busy_on", busy, 1);
    n = 0;
    while (!done && n < 200) begin
      if (disturb && n == 5) begin
        keys = 2'b10; in_numb = WIDTH'(1); arif = 4'b1110; start = 1'b1;
      end else begin
        keys = 2'b00; start = 1'b0;
      end
      tick();
      n++;
    end
    chk("latency", n, lat);
    chk("busy_off", busy, 0);
    chk("result", result, r);
    chk("neg", neg, n_exp);
    chk("div0", div0, z_exp);
    chk("ovf", ovf, r > 9999);
    chk("bcd", bcd, to_bcd(r));
    chk("dot_pos", dot_pos, (op == 4'b0111) ? FRAC : 0);
    tick();
    chk("done_pulse", done, 0);
    chk("result_hold", result, r);
  endtask

  initial begin
    logic [3:0] ops [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bit seen;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_flags", {neg, div0, ovf, dot_pos}, 0);
    repeat (2) tick();
    rst_ALU = 1'b0;
    tick();

    run_op(4'b1110, 25, 17, 0);
    run_op(4'b1101, 17, 25, 0);
    run_op(4'b1101, 25, 17, 0);
    run_op(4'b1011, 123, 45, 0);
    run_op(4'b1011, 2047, 2047, 0);
    run_op(4'b0111, 7, 3, 0);
    run_op(4'b0111, 2, 3, 0);
    run_op(4'b0111, 5, 0, 0);
    run_op(4'b0111, 2047, 1, 0);
    run_op(4'b1110, 0, 0, 0);
    run_op(4'b1011, 123, 45, 1);

    // invalid op code must not start anything
    arif = 4'b1111; start = 1'b1; tick();
    start = 1'b0;
    chk("inv_busy", busy, 0);
    repeat (3) tick();
    chk("inv_done", done, 0);

    // reset mid-MUL: abort with no done pulse
    keys = 2'b11; in_numb = WIDTH'(300); tick();
    keys = 2'b00; arif = 4'b1011; start = 1'b1; tick();
    start = 1'b0;
    repeat (10) tick();
    rst_ALU = 1'b1; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_bcd", bcd, 0);
    tick();
    rst_ALU = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen = 1;
    end
    chk("midrst_nodone", seen, 0);
    chk("midrst_hold", result, 0);

    for (int i = 0; i < 16; i++) begin
      int a, b;
      logic [3:0] op;
      op = ops[$urandom_range(0, 3)];
      a  = $urandom_range(0, (i % 2) ? 2047 : 99);
      b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 2047);
      run_op(op, a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
